// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle between an SPI master and the register-file slave.
//   spi_ss_i      slave select, active low (master -> slave)
//   spi_mosi_i    serial data to slave, MSB first (master -> slave)
//   spi_miso_o    serial data from slave, MSB first (slave -> master)
//   spi_miso_oe_o MISO output enable for the pad driver (slave -> master)
interface spi_reg_slave_if;
  logic spi_ss_i;
  logic spi_mosi_i;
  logic spi_miso_o;
  logic spi_miso_oe_o;

  modport master (
    output spi_ss_i,
    output spi_mosi_i,
    input  spi_miso_o,
    input  spi_miso_oe_o
  );

  modport slave (
    input  spi_ss_i,
    input  spi_mosi_i,
    output spi_miso_o,
    output spi_miso_oe_o
  );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI slave register file. Frames are ADDR_W address bits (MSB = read flag,
// remaining bits = register index) followed by DATA_W data bits, MSB first.
// Writes land in a bank of NUM_REGS registers exported flat; reads return the
// addressed register on MISO during the data phase.
// Ports:
//   SPI_clk_x   SPI clock: MOSI sampled on rising edge, MISO updated on falling edge
//   HRESETn     asynchronous active-low reset
//   bus         SPI pins (ss, mosi, miso, miso_oe) via spi_reg_slave_if.slave
//   regs_o      flat register bank, reg i at [i*DATA_W +: DATA_W]
//   wr_toggle_o flips once per committed write (consumer syncs this, then samples regs_o)
//   last_idx_o  index addressed by the last completed frame
//   err_o       last completed frame addressed an index >= NUM_REGS
module spi_reg_slave #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter int                NUM_REGS  = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       SPI_clk_x,
  input  logic                       HRESETn,
  spi_reg_slave_if.slave             bus,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_toggle_o,
  output logic [ADDR_W-2:0]          last_idx_o,
  output logic                       err_o
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int IDX_W   = ADDR_W - 1;
  localparam int SH_W    = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) - 1;

  typedef enum logic {PH_ADDR, PH_DATA} phase_e;

  logic [CNT_W-1:0]  cnt;
  logic [SH_W-1:0]   shift;
  logic              frame_rst_n;
  phase_e            phase;
  logic              addr_last;
  logic              frame_last;
  logic [ADDR_W-1:0] addr_word;
  logic [DATA_W-1:0] data_word;
  logic [IDX_W-1:0]  addr_idx;
  logic              addr_rd;
  logic              addr_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rw_q;
  logic [IDX_W-1:0]  idx_q;
  logic              idx_valid_q;
  logic [DATA_W-1:0] tx_q;
  logic [CNT_W-1:0]  data_bit;
  logic [DATA_W-1:0] tx_aligned;
  logic              wr_commit;
  logic [DATA_W-1:0] regs [NUM_REGS];

  assign bus.spi_miso_oe_o = ~bus.spi_ss_i;

  // Deasserting slave select discards any partial frame: the counter and input
  // shifter share the system reset path with ss so they clear without a clock.
  assign frame_rst_n = HRESETn & ~bus.spi_ss_i;

  assign addr_last  = (cnt == CNT_W'(ADDR_W - 1));
  assign frame_last = (cnt == CNT_W'(FRAME_W - 1));
  assign phase      = (cnt >= CNT_W'(ADDR_W)) ? PH_DATA : PH_ADDR;

  // The bit arriving on this edge completes the field, so fields are taken
  // from the shifter concatenated with the live MOSI bit.
  assign addr_word  = {shift[ADDR_W-2:0], bus.spi_mosi_i};
  assign data_word  = {shift[DATA_W-2:0], bus.spi_mosi_i};
  assign addr_rd    = addr_word[ADDR_W-1];
  assign addr_idx   = addr_word[IDX_W-1:0];
  assign addr_valid = ({1'b0, addr_idx} < (IDX_W + 1)'(NUM_REGS));

  always_ff @(posedge SPI_clk_x or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      cnt   <= '0;
      shift <= '0;
    end else begin
      shift <= {shift[SH_W-2:0], bus.spi_mosi_i};
      cnt   <= frame_last ? '0 : cnt + CNT_W'(1);
    end
  end

  // Read mux; an out-of-range index matches no register and yields zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_idx == IDX_W'(i)) rd_data = regs[i];
    end
  end

  // Address latch and transmit load at the end of the address phase.
  always_ff @(posedge SPI_clk_x or negedge HRESETn) begin
    if (!HRESETn) begin
      rw_q        <= 1'b0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      tx_q        <= '0;
    end else if (addr_last) begin
      rw_q        <= addr_rd;
      idx_q       <= addr_idx;
      idx_valid_q <= addr_valid;
      tx_q        <= (addr_rd && addr_valid) ? rd_data : '0;
    end
  end

  // On the falling edge cnt already points at the data bit being presented,
  // so shifting tx left by the data-phase offset exposes that bit at the MSB.
  assign data_bit   = cnt - CNT_W'(ADDR_W);
  assign tx_aligned = tx_q << data_bit;

  always_ff @(negedge SPI_clk_x or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.spi_miso_o <= 1'b0;
    end else if (phase == PH_DATA) begin
      bus.spi_miso_o <= tx_aligned[DATA_W-1];
    end else begin
      bus.spi_miso_o <= 1'b0;
    end
  end

  // Commit on the last bit of a frame; status reflects every completed frame,
  // registers and the toggle only valid writes.
  assign wr_commit = frame_last && !rw_q && idx_valid_q;

  always_ff @(posedge SPI_clk_x or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      wr_toggle_o <= 1'b0;
      last_idx_o  <= '0;
      err_o       <= 1'b0;
    end else if (frame_last) begin
      last_idx_o <= idx_q;
      err_o      <= ~idx_valid_q;
      if (wr_commit) begin
        wr_toggle_o <= ~wr_toggle_o;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (idx_q == IDX_W'(i)) regs[i] <= data_word;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule
